fpu_arbiter: RTL
================

// Module: fpu_arbiter
// PURPOSE
//  Shares one FPU instance between NUM_REQ requesters (e.g. integer pipe, vector/debug unit) with one op in flight.
//  Round-robin grant, operand capture, response routing back to the owner, per-requester sticky fflags.
//  Sits between the requesters' issue/writeback paths and the FPU valid/ready interface.
// PARAMETERS
//  NUM_REQ   2   number of requesters, 2..8; owner index width IW = $clog2(NUM_REQ), min 1
// PORTS
//  clk           in   1           clock
//  reset         in   1           asynchronous, active-high reset
//  flush         in   1           synchronous global kill; forwarded to FPU
//  req_valid     in   NUM_REQ     request valid per requester
//  req_ready     out  NUM_REQ     request accepted (one-hot or zero)
//  req_op        in   NUM_REQ*5   FPU opcode (FPU_pkg encoding)
//  req_rm        in   NUM_REQ*3   rounding mode
//  req_a/b/c     in   NUM_REQ*32  operands each
//  rsp_valid     out  NUM_REQ     result valid, owner only
//  rsp_ready     in   NUM_REQ     requester accepts result
//  rsp_y         out  32          result, shared bus, meaningful when any rsp_valid
//  rsp_flags     out  5           {IV,DZ,OF,UF,IE} of this result
//  acc_flags     out  NUM_REQ*5   sticky accumulated fflags per requester
//  clr_flags     in   NUM_REQ     clear that requester's acc_flags
//  fpu_flush     out  1           = flush
//  fpu_valid_in  out  1           to FPU valid_in
//  fpu_ready_out in   1           from FPU ready_out
//  fpu_valid_out in   1           from FPU valid_out
//  fpu_ready_in  out  1           to FPU ready_in
//  fpu_op/rm/a/b/c out 5/3/32x3   captured operation to FPU
//  fpu_y         in   32          FPU result
//  fpu_IV..IE    in   1 each      FPU exception flags
// BEHAVIOUR
//  - Reset: state IDLE, rr_ptr 0, owner 0, operand regs 0, acc_flags 0; all valid/ready outputs 0.
//  - IDLE: winner = first req_valid at/after rr_ptr (wrapping). req_ready[winner]=1 same cycle (combinational);
//    on that handshake capture op/rm/a/b/c and owner, go ISSUE. No request -> stay IDLE.
//  - ISSUE: fpu_valid_in=1, operands from capture regs (stable). On fpu_ready_out go WAIT.
//  - WAIT: fpu_ready_in = rsp_ready[owner]; rsp_valid[owner] = fpu_valid_out; rsp_y/rsp_flags pass through
//    combinationally. On fpu_valid_out && rsp_ready[owner]: acc_flags[owner] |= flags,
//    rr_ptr <= owner+1 (wrap at NUM_REQ), go IDLE. Earliest next grant: cycle after response handshake.
//  - req_ready is 0 outside IDLE; rsp_valid of non-owners always 0; fpu_ready_in 0 outside WAIT.
//  - Fairness: requester held valid is granted within NUM_REQ ops.
//  - flush: highest priority, any state -> IDLE, in-flight result discarded (no rsp_valid, no flag update),
//    rr_ptr unchanged; a req handshake in the flush cycle is void (req_ready forced 0).
//  - clr_flags[i] with same-cycle accumulate on i: clear first, then OR new flags (new flags survive).
//  - FPU fused ops (MADD etc.) are one op here; internal two-pass sequencing is the FPU's concern.
//  - Reset mid-operation: immediate return to reset values; FPU receives its own reset.
// STRUCTURE
//  - FPU_pkg: fpu_arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT}; fpu_flags_t packed struct {IV,DZ,OF,UF,IE}.
//  - Sub-module fpu_rr_pick: combinational round-robin picker (req vector, rr_ptr -> one-hot grant, index, any).
//  - Arbiter itself: FSM, capture regs, owner/rr_ptr regs, acc_flags regs, response muxing.
// TESTING
//  1 Single req0 ADD a=3F800000 b=40000000 -> req_ready[0] cycle 0, fpu_valid_in cycle 1, rsp_valid[0] y=40400000 flags 0.
//  2 req0,req1 both valid continuously, 6 ops -> grant order 0,1,0,1,0,1; never two outstanding.
//  3 req1 DIV a=3F800000 b=00000000 -> rsp_flags DZ=1, acc_flags[1]=5'b01000, acc_flags[0]=0; clr_flags[1] -> 0.
//  4 rsp_ready[0] low 5 cycles during WAIT -> rsp_valid[0] held, fpu_ready_in 0, no new grant, y stable.
//  5 flush in WAIT -> IDLE next cycle, no rsp_valid, acc_flags unchanged; pending req1 granted next.
//  6 reset asserted in ISSUE -> all outputs 0 asynchronously; after release first grant goes to req0.

Source files
------------

// File: rtl/fpu_arbiter_pkg.sv
// Shared types for the FPU arbiter: FSM states, exception-flag layout, opcode encoding.
// Pure declarations, no timing or handshake behaviour of its own.
package fpu_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT
   } fpu_arb_state_t;

   typedef struct packed {
      logic IV;
      logic DZ;
      logic OF;
      logic UF;
      logic IE;
   } fpu_flags_t;

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_MUL  = 5'd2;
   localparam logic [4:0] OP_DIV  = 5'd3;
   localparam logic [4:0] OP_MADD = 5'd4;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fpu_rr_pick.sv
// Round-robin picker: first asserted request at or after i_ptr, wrapping at NUM_REQ.
// Purely combinational, no backpressure of its own.
module fpu_rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IW      = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IW-1:0]      o_idx,
   output logic               o_any
);

   logic [IW:0] w_sum;

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_sum = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, i_ptr} + (IW+1)'(k);
         if (w_sum >= (IW+1)'(NUM_REQ)) w_sum = w_sum - (IW+1)'(NUM_REQ);
         if (!o_any && i_req[w_sum[IW-1:0]]) begin
            o_any                 = 1'b1;
            o_idx                 = w_sum[IW-1:0];
            o_gnt[w_sum[IW-1:0]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one FPU among NUM_REQ requesters, one op in flight; round-robin grant, sticky per-requester fflags.
// Grant same cycle in IDLE, issue next cycle; response stalls on the owner's rsp_ready, flush kills any state.
module fpu_arbiter
   import fpu_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*5-1:0] req_op,
   input  logic [NUM_REQ*3-1:0] req_rm,
   input  logic [NUM_REQ*32-1:0] req_a,
   input  logic [NUM_REQ*32-1:0] req_b,
   input  logic [NUM_REQ*32-1:0] req_c,
   output logic [NUM_REQ-1:0]   rsp_valid,
   input  logic [NUM_REQ-1:0]   rsp_ready,
   output logic [31:0]          rsp_y,
   output logic [4:0]           rsp_flags,
   output logic [NUM_REQ*5-1:0] acc_flags,
   input  logic [NUM_REQ-1:0]   clr_flags,
   output logic                 fpu_flush,
   output logic                 fpu_valid_in,
   input  logic                 fpu_ready_out,
   input  logic                 fpu_valid_out,
   output logic                 fpu_ready_in,
   output logic [4:0]           fpu_op,
   output logic [2:0]           fpu_rm,
   output logic [31:0]          fpu_a,
   output logic [31:0]          fpu_b,
   output logic [31:0]          fpu_c,
   input  logic [31:0]          fpu_y,
   input  logic                 fpu_IV,
   input  logic                 fpu_DZ,
   input  logic                 fpu_OF,
   input  logic                 fpu_UF,
   input  logic                 fpu_IE
);

   localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

   fpu_arb_state_t       r_state;
   fpu_arb_state_t       w_state_nxt;
   logic [IW-1:0]        r_rr_ptr;
   logic [IW-1:0]        r_owner;
   logic [4:0]           r_op;
   logic [2:0]           r_rm;
   logic [31:0]          r_a;
   logic [31:0]          r_b;
   logic [31:0]          r_c;
   logic [NUM_REQ*5-1:0] r_acc_flags;
   logic [NUM_REQ*5-1:0] w_acc_nxt;

   logic [NUM_REQ-1:0]   w_gnt;
   logic [IW-1:0]        w_idx;
   logic                 w_any;
   logic                 w_req_hs;
   logic                 w_rsp_hs;
   fpu_flags_t           w_flags;
   logic [4:0]           w_sel_op;
   logic [2:0]           w_sel_rm;
   logic [31:0]          w_sel_a;
   logic [31:0]          w_sel_b;
   logic [31:0]          w_sel_c;

   fpu_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .i_req (req_valid),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign w_flags = fpu_flags_t'({fpu_IV, fpu_DZ, fpu_OF, fpu_UF, fpu_IE});

   always_comb begin
      w_sel_op = '0;
      w_sel_rm = '0;
      w_sel_a  = '0;
      w_sel_b  = '0;
      w_sel_c  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_idx == IW'(i)) begin
            w_sel_op = req_op[i*5 +: 5];
            w_sel_rm = req_rm[i*3 +: 3];
            w_sel_a  = req_a[i*32 +: 32];
            w_sel_b  = req_b[i*32 +: 32];
            w_sel_c  = req_c[i*32 +: 32];
         end
      end
   end

   // Every handshake is gated by flush so a killed cycle neither grants nor retires.
   always_comb begin
      w_state_nxt  = r_state;
      req_ready    = '0;
      rsp_valid    = '0;
      fpu_valid_in = 1'b0;
      fpu_ready_in = 1'b0;
      w_req_hs     = 1'b0;
      w_rsp_hs     = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (!flush) begin
               req_ready = w_gnt;
               if (w_any) begin
                  w_req_hs    = 1'b1;
                  w_state_nxt = ARB_ISSUE;
               end
            end
         end
         ARB_ISSUE: begin
            if (!flush) begin
               fpu_valid_in = 1'b1;
               if (fpu_ready_out) w_state_nxt = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (!flush) begin
               fpu_ready_in       = rsp_ready[r_owner];
               rsp_valid[r_owner] = fpu_valid_out;
               if (fpu_valid_out && rsp_ready[r_owner]) begin
                  w_rsp_hs    = 1'b1;
                  w_state_nxt = ARB_IDLE;
               end
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
      if (flush) w_state_nxt = ARB_IDLE;
   end

   // Clear applies before the accumulate so flags retired in the same cycle survive.
   always_comb begin
      w_acc_nxt = r_acc_flags;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (clr_flags[i]) w_acc_nxt[i*5 +: 5] = '0;
         if (w_rsp_hs && r_owner == IW'(i)) w_acc_nxt[i*5 +: 5] = w_acc_nxt[i*5 +: 5] | w_flags;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ARB_IDLE;
         r_rr_ptr    <= '0;
         r_owner     <= '0;
         r_op        <= '0;
         r_rm        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_c         <= '0;
         r_acc_flags <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc_flags <= w_acc_nxt;
         if (w_req_hs) begin
            r_owner <= w_idx;
            r_op    <= w_sel_op;
            r_rm    <= w_sel_rm;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_c     <= w_sel_c;
         end
         if (w_rsp_hs) r_rr_ptr <= IW'(rr_next(int'(r_owner), NUM_REQ));
      end
   end

   assign fpu_flush = flush;
   assign fpu_op    = r_op;
   assign fpu_rm    = r_rm;
   assign fpu_a     = r_a;
   assign fpu_b     = r_b;
   assign fpu_c     = r_c;
   assign acc_flags = r_acc_flags;
   assign rsp_y     = (r_state == ARB_WAIT) ? fpu_y : '0;
   assign rsp_flags = (r_state == ARB_WAIT) ? w_flags : '0;

endmodule
